vip_vid2axis: RTL and testbench
===============================

Name: vip_vid2axis

Overview:
- Downstream stage of the VIP pipeline. Consumes the href/vsync/pixel video bus at the pipeline output and emits an AXI4-Stream video stream for the VDMA write channel.
- Marks tuser on the first pixel of each frame and tlast on the last pixel of each line.
- Absorbs sink backpressure in an internal FIFO and detects overflow, resynchronising at the next frame.

Parameters:
- BITS, 8, bits per colour component.
- FIFO_ADDR_BITS, 11, log2 of FIFO depth (default depth 2048 entries, at least one full line).
- CNT_BITS, 16, width of the dropped-frame counter.

Ports:
- pclk  in  1  pixel clock; used for all logic.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  stream enable; sampled only at frame start.
- ovf_clr  in  1  one-cycle pulse; clears the sticky overflow flag.
- in_href  in  1  line valid, active high.
- in_vsync  in  1  frame sync, active high; frame starts on its rising edge.
- in_data  in  3*BITS  pixel, packed {r,b,g} MSB to LSB.
- m_axis_tdata  out  3*BITS  pixel, same packing as in_data.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tuser  out  1  start of frame.
- m_axis_tlast  out  1  end of line.
- overflow  out  1  sticky; set when a pixel is lost to a full FIFO.
- drop_cnt  out  CNT_BITS  count of frames truncated by overflow; saturates.
- fifo_level  out  FIFO_ADDR_BITS+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a pclk edge):
  - All outputs are 0: tvalid, tuser, tlast, tdata, overflow, drop_cnt, fifo_level.
  - FIFO is emptied and the state machine goes to IDLE.
  - Reset mid-frame discards all buffered and held pixels.
- Input stage:
  - in_href, in_vsync and in_data are registered once.
  - vsync rising edge = vs_d0 & ~vs_d1.
  - Each valid pixel is held one cycle in a hold register so its tlast value can be decided.
  - Pixel P captured at cycle N is written at edge N+1, with last=1 iff href is low in cycle N+1.
- FIFO entry = {user, last, data}, 3*BITS+2 bits wide.
- FSM states:
  - IDLE: wait for a vsync rising edge. On the edge: if en=1, go to ACTIVE and set sof_pending=1; if en=0, stay in IDLE.
  - ACTIVE: write each held pixel. The first write after sof_pending carries user=1 and clears sof_pending. A vsync rising edge re-arms sof_pending and stays in ACTIVE if en=1, otherwise goes to IDLE; the held pixel is still written first.
  - DROP: discard all input. On a vsync rising edge, behave as IDLE does.
- Overflow:
  - A write attempted while the FIFO is full is discarded.
  - overflow is set to 1, drop_cnt increments (saturating), and the FSM goes to DROP.
  - Pixels already in the FIFO still drain normally.
- ovf_clr clears overflow. If ovf_clr and a new overflow occur in the same cycle, overflow stays 1.
- Simultaneous read and write on a full FIFO: the write is accepted, since the read frees a slot in the same cycle.
- Output side:
  - FWFT output register; tvalid is asserted whenever the FIFO is non-empty.
  - tdata, tuser and tlast hold stable while tvalid=1 and tready=0.
  - A beat transfers on tvalid & tready.
  - Full throughput: one beat per cycle when tready=1.
- Latency: with tready=1 and an empty FIFO, the first pixel appears on tvalid 3 cycles after it is presented (input register, hold register, FIFO write/FWFT).
- Single-pixel line (href high for one cycle): that beat carries last=1, and user=1 if it is the first pixel of the frame.
- en is never used to flush; changing en mid-frame has no effect until the next vsync rising edge. This keeps the AXIS stream legal.
- fifo_level updates one cycle after the write or read that changes it.

Decomposition:
- Package vip_axis_pkg holds:
  - localparam ENTRY_W = 3*BITS+2 as a function of BITS;
  - the FSM state encoding IDLE=2'd0, ACTIVE=2'd1, DROP=2'd2;
  - bit-index constants USER_BIT and LAST_BIT.
- One sub-module, vip_sync_fifo:
  - single clock, FWFT;
  - parameterised by width and address bits;
  - ports: full, empty, level, synchronous active-low reset.
- Top level contains the input/hold registers, the FSM, and the overflow/drop_cnt logic.

Test Plan:
- Frame 4x2 pixels, data 1..8, tready=1, en=1 → 8 beats in order; tuser=1 on beat 1 only; tlast=1 on beats 4 and 8; overflow=0.
- Same frame with tready=0 for the first 20 cycles, then 1 → fifo_level peaks at 8; all 8 beats delivered; tdata stable while stalled.
- FIFO_ADDR_BITS=4, single 32-pixel line, tready=0 → first 16 pixels stored; overflow=1, drop_cnt=1. After tready=1: exactly 16 beats. Next frame delivers cleanly with tuser on its first beat. ovf_clr then gives overflow=0.
- en=0 at the vsync edge, then en=1 mid-frame → no beats for that frame; the next frame with en=1 is delivered fully.
- Single-pixel lines: href high 1 cycle on each of 3 lines, data A, B, C → beats A(user=1, last=1), B(last=1), C(last=1).
- rst_n low for 1 cycle after 2 pixels of a line → all outputs 0 the next cycle, fifo_level=0; next frame delivered correctly with tuser.

Source files
------------

// File: rtl/vip_axis_pkg.sv
// rtl/vip_axis_pkg.sv - shared types and entry layout for the video-to-AXIS bridge
package vip_axis_pkg;

  localparam int BITS_DEFAULT = 8;

  // FIFO entry is {user, last, data}; the helpers keep the layout tied to BITS.
  function automatic int entry_w(input int bits);
    return 3 * bits + 2;
  endfunction

  function automatic int user_bit(input int bits);
    return 3 * bits + 1;
  endfunction

  function automatic int last_bit(input int bits);
    return 3 * bits;
  endfunction

  localparam int ENTRY_W  = entry_w(BITS_DEFAULT);
  localparam int USER_BIT = user_bit(BITS_DEFAULT);
  localparam int LAST_BIT = last_bit(BITS_DEFAULT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } vid_state_e;

endpackage

// File: rtl/vip_sync_fifo.sv
// rtl/vip_sync_fifo.sv - single-clock FWFT FIFO with a registered output stage
module vip_sync_fifo #(
  parameter int WIDTH     = 26,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   level
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_L = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]   mem_cnt_q, level_q;
  logic [WIDTH-1:0]     out_q;
  logic                 out_valid_q;

  logic rd_ok, wr_ok, out_free, mem_empty, load_mem, wr_out, wr_mem;

  // The output register counts toward occupancy, so the array never holds more than DEPTH-1.
  always_comb begin
    rd_ok     = rd_en & out_valid_q;
    wr_ok     = wr_en & ((level_q != DEPTH_L) | rd_ok);
    out_free  = ~out_valid_q | rd_ok;
    mem_empty = (mem_cnt_q == '0);
    load_mem  = out_free & ~mem_empty;
    wr_out    = wr_ok & out_free & mem_empty;
    wr_mem    = wr_ok & ~wr_out;
  end

  always_ff @(posedge clk) begin
    if (wr_mem) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      level_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_mem) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (load_mem) begin
        out_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end else if (wr_out) begin
        out_q <= wr_data;
      end
      out_valid_q <= load_mem | wr_out | (out_valid_q & ~rd_ok);
      case ({wr_mem, load_mem})
        2'b10:   mem_cnt_q <= mem_cnt_q + CNT_ONE;
        2'b01:   mem_cnt_q <= mem_cnt_q - CNT_ONE;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + CNT_ONE;
        2'b01:   level_q <= level_q - CNT_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data = out_q;
  assign full    = (level_q == DEPTH_L);
  assign empty   = ~out_valid_q;
  assign level   = level_q;

endmodule

// File: rtl/vip_vid2axis.sv
// rtl/vip_vid2axis.sv - href/vsync video bus to AXI4-Stream video with overflow resync
module vip_vid2axis
  import vip_axis_pkg::*;
#(
  parameter int BITS           = 8,
  parameter int FIFO_ADDR_BITS = 11,
  parameter int CNT_BITS       = 16
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      ovf_clr,
  input  logic                      in_href,
  input  logic                      in_vsync,
  input  logic [3*BITS-1:0]         in_data,
  output logic [3*BITS-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      overflow,
  output logic [CNT_BITS-1:0]       drop_cnt,
  output logic [FIFO_ADDR_BITS:0]   fifo_level
);

  localparam int DW = 3 * BITS;
  localparam int EW = entry_w(BITS);
  localparam int UB = user_bit(BITS);
  localparam int LB = last_bit(BITS);
  localparam logic [CNT_BITS-1:0] DROP_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic          href_q, vs0_q, vs1_q;
  logic [DW-1:0] data_q;
  logic          hold_valid_q;
  logic [DW-1:0] hold_data_q;

  vid_state_e    state_q, state_d;
  logic          sof_q, sof_d;
  logic          overflow_q, overflow_d;
  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  logic          vs_rise, rd_beat, fifo_full, fifo_empty;
  logic          wr_try, wr_ok, ovf_event;
  logic [EW-1:0] wr_entry, rd_entry;

  // A pixel sits one cycle in the hold register so the following href tells us if it ends the line.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      href_q       <= 1'b0;
      vs0_q        <= 1'b0;
      vs1_q        <= 1'b0;
      data_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      href_q       <= in_href;
      vs0_q        <= in_vsync;
      vs1_q        <= vs0_q;
      data_q       <= in_data;
      hold_valid_q <= href_q;
      hold_data_q  <= data_q;
    end
  end

  assign vs_rise = vs0_q & ~vs1_q;
  assign rd_beat = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sof_q      <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sof_q      <= sof_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // The held pixel is written before a coincident vsync re-arms start-of-frame.
  always_comb begin
    state_d = state_q;
    sof_d   = sof_q;
    case (state_q)
      ACTIVE: begin
        if (ovf_event) begin
          state_d = DROP;
        end else if (wr_ok) begin
          sof_d = 1'b0;
        end
        if (vs_rise) begin
          sof_d   = 1'b1;
          state_d = en ? ACTIVE : IDLE;
        end
      end
      IDLE, DROP: begin
        if (vs_rise) begin
          state_d = en ? ACTIVE : IDLE;
          sof_d   = en;
        end
      end
      default: begin
        state_d = IDLE;
        sof_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_try     = hold_valid_q & (state_q == ACTIVE);
    wr_ok      = wr_try & (~fifo_full | rd_beat);
    ovf_event  = wr_try & ~wr_ok;
    wr_entry   = {sof_q, ~href_q, hold_data_q};
    overflow_d = ovf_event | (overflow_q & ~ovf_clr);
    drop_cnt_d = drop_cnt_q;
    if (ovf_event && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end
  end

  vip_sync_fifo #(
    .WIDTH     (EW),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk     (pclk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_data (wr_entry),
    .rd_en   (rd_beat),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = rd_entry[DW-1:0];
  assign m_axis_tuser  = rd_entry[UB];
  assign m_axis_tlast  = rd_entry[LB];
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_vip_vid2axis.sv
// tb/tb_vip_vid2axis.sv - randomized frame-level bench with a beat-list reference model
module tb_vip_vid2axis;

  localparam int BITS = 8;
  localparam int AB   = 4;
  localparam int CB   = 16;
  localparam int DW   = 3 * BITS;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          in_href = 1'b0;
  logic          in_vsync = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          overflow;
  logic [CB-1:0] drop_cnt;
  logic [AB:0]   fifo_level;

  vip_vid2axis #(.BITS(BITS), .FIFO_ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .ovf_clr(ovf_clr),
    .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .overflow(overflow),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_pix_cyc = 0;
  int first_valid_cyc = 0;
  bit seen_valid = 0;
  bit stall_prev = 0;
  logic [DW+1:0] stall_entry;
  int max_level = 0;

  logic [DW-1:0] px_q[$];
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] obs_q[$];

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (rst_n && m_axis_tvalid) begin
      if (!seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (stall_prev) begin
        checks++;
        if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== stall_entry) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, stall_entry);
        end
      end
      if (m_axis_tready) obs_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      stall_prev = !m_axis_tready;
      stall_entry = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end else begin
      stall_prev = 0;
    end
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach summary, got hang want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic start_frame(input bit en_vs, input bit en_after);
    en = en_vs;
    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
    en = en_after;
    tick();
    tick();
  endtask

  task automatic drive_frame(input int lines, input int ppl, input bit en_vs,
                             input bit en_after, input bit rand_data, input int base);
    px_q.delete();
    start_frame(en_vs, en_after);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        in_href = 1'b1;
        in_data = rand_data ? DW'($urandom) : DW'(base + l * ppl + p);
        if (l == 0 && p == 0) first_pix_cyc = cyc;
        px_q.push_back(in_data);
        tick();
      end
      in_href = 1'b0;
      in_data = '0;
      repeat (3) tick();
    end
  endtask

  // Expected beats: frame pixels in order, user on the first, last at each line end, truncated at limit.
  task automatic model_frame(input int lines, input int ppl, input int limit);
    logic [DW+1:0] e;
    for (int i = 0; i < lines * ppl && i < limit; i++) begin
      e = {(i == 0), ((i % ppl) == ppl - 1), px_q[i]};
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b want 0", m_axis_tuser); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_basic();
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b1;
    seen_valid = 0;
    drive_frame(2, 4, 1'b1, 1'b1, 1'b0, 1);
    model_frame(2, 4, 1000);
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    checks++; if (first_valid_cyc - first_pix_cyc !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", first_valid_cyc - first_pix_cyc); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b0;
    max_level = 0;
    drive_frame(2, 4, 1'b1, 1'b1, 1'b1, 0);
    model_frame(2, 4, 1000);
    repeat (5) tick();
    checks++; if (fifo_level !== 5'd8) begin errors++; $display("FAIL bp_level: got %0d want 8", fifo_level); end
    checks++; if (max_level !== 8) begin errors++; $display("FAIL bp_peak: got %0d want 8", max_level); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL bp_no_beats: got %0d want 0", obs_q.size()); end
    m_axis_tready = 1'b1;
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b0;
    drive_frame(1, 32, 1'b1, 1'b1, 1'b1, 0);
    model_frame(1, 32, 1 << AB);
    repeat (5) tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    m_axis_tready = 1'b1;
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    drive_frame(2, 4, 1'b1, 1'b1, 1'b1, 0);
    model_frame(2, 4, 1000);
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL resync_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL resync_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt_keep: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_enable();
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b1;
    drive_frame(2, 4, 1'b0, 1'b1, 1'b1, 0);
    repeat (10) tick();
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL en_off_beats: got %0d want 0", obs_q.size()); end
    drive_frame(2, 4, 1'b1, 1'b1, 1'b1, 0);
    model_frame(2, 4, 1000);
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL en_on_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL en_on_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_single_pixel();
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b1;
    drive_frame(3, 1, 1'b1, 1'b1, 1'b1, 0);
    model_frame(3, 1, 1000);
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_q.delete(); exp_q.delete();
    m_axis_tready = 1'b1;
    start_frame(1'b1, 1'b1);
    in_href = 1'b1;
    in_data = DW'($urandom);
    tick();
    in_data = DW'($urandom);
    tick();
    in_href = 1'b0;
    in_data = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== '0) begin errors++; $display("FAIL mid_rst_beat: got %h want 0", {m_axis_tuser, m_axis_tlast, m_axis_tdata}); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL mid_rst_drop_cnt: got %0d want 0", drop_cnt); end
    repeat (6) tick();
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL mid_rst_discard: got %0d want 0", obs_q.size()); end
    drive_frame(2, 3, 1'b1, 1'b1, 1'b1, 0);
    model_frame(2, 3, 1000);
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_next_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mid_next_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_enable();
    test_single_pixel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
